// File: rtl/fp_square_seq.sv
// Sequential IEEE-754 single/double squarer using a one-bit-per-cycle shift-add significand multiplier.
// Results are always positive; underflow flushes to +0.
module fp_square_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] operand_a,
    input  logic        is_double_precision,
    input  logic [2:0]  rounding_mode,
    output logic        ready,
    output logic        valid_out,
    output logic [63:0] result,
    output logic        flag_invalid,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_PACK, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d, valid_q, valid_d;
    logic [63:0]        result_q, result_d;
    logic               inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
    logic               dp_q, dp_d;
    logic [2:0]         mode_q, mode_d;
    logic               special_q, special_d;
    logic [63:0]        spec_res_q, spec_res_d;
    logic               spec_inv_q, spec_inv_d;
    logic [52:0]        m_q, m_d, mplr_q, mplr_d;
    logic [105:0]       acc_q, acc_d, norm_q, norm_d;
    logic [5:0]         cnt_q, cnt_d;
    logic signed [12:0] e_q, e_d, e2_q, e2_d;

    logic [10:0]        in_exp;
    logic [51:0]        in_frac;
    logic               exp_ones, exp_zero, frac_zero, frac_msb;
    logic [106:0]       addend, sum;
    logic [105:0]       aligned;
    logic [6:0]         lz;
    logic [52:0]        kept;
    logic               g, r, s, inexact, round_up;
    logic [53:0]        mant;
    logic signed [12:0] e2r, emax, emin, biased;
    logic               unused_bits;

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        result_d   = result_q;
        inv_d      = inv_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inx_d      = inx_q;
        dp_d       = dp_q;
        mode_d     = mode_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        spec_inv_d = spec_inv_q;
        m_d        = m_q;
        mplr_d     = mplr_q;
        acc_d      = acc_q;
        norm_d     = norm_q;
        cnt_d      = cnt_q;
        e_d        = e_q;
        e2_d       = e2_q;

        in_exp    = is_double_precision ? operand_a[62:52] : {3'b0, operand_a[30:23]};
        in_frac   = is_double_precision ? operand_a[51:0] : {29'b0, operand_a[22:0]};
        exp_ones  = is_double_precision ? (operand_a[62:52] == 11'h7FF) : (operand_a[30:23] == 8'hFF);
        exp_zero  = (in_exp == '0);
        frac_zero = (in_frac == '0);
        frac_msb  = is_double_precision ? operand_a[51] : operand_a[22];

        // SP adds at bit N=24 so the 48-bit product lands right-aligned after 24 shifts
        addend = dp_q ? {1'b0, m_q, 53'b0} : {59'b0, m_q[23:0], 24'b0};
        sum    = {1'b0, acc_q} + (mplr_q[0] ? addend : '0);

        aligned = dp_q ? acc_q : {acc_q[47:0], 58'b0};
        lz = '0;
        for (int unsigned i = 0; i < 106; i++) begin
            if (aligned[i]) lz = 7'(105 - i);
        end

        kept     = dp_q ? norm_q[105:53] : {29'b0, norm_q[105:82]};
        g        = dp_q ? norm_q[52] : norm_q[81];
        r        = dp_q ? norm_q[51] : norm_q[80];
        s        = dp_q ? |norm_q[50:0] : |norm_q[79:0];
        inexact  = g | r | s;
        round_up = ((mode_q == 3'b000) && g && (r || s || kept[0])) ||
                   ((mode_q == 3'b011) && inexact);
        mant     = {1'b0, kept} + {53'b0, round_up};
        e2r      = e2_q;
        if (dp_q ? mant[53] : mant[24]) begin
            mant = mant >> 1;
            e2r  = e2_q + 13'sd1;
        end
        emax   = dp_q ? 13'sd1023 : 13'sd127;
        emin   = dp_q ? -13'sd1022 : -13'sd126;
        biased = e2r + emax;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dp_d   = is_double_precision;
                    mode_d = rounding_mode;
                    m_d    = is_double_precision ? {~exp_zero, in_frac}
                                                 : {29'b0, ~exp_zero, in_frac[22:0]};
                    mplr_d = m_d;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (is_double_precision)
                        e_d = exp_zero ? -13'sd1022 : $signed({2'b0, in_exp}) - 13'sd1023;
                    else
                        e_d = exp_zero ? -13'sd126 : $signed({2'b0, in_exp}) - 13'sd127;
                    special_d  = exp_ones | (exp_zero & frac_zero);
                    spec_inv_d = exp_ones & ~frac_zero & ~frac_msb;
                    if (exp_ones && !frac_zero)
                        spec_res_d = is_double_precision ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
                    else if (exp_ones)
                        spec_res_d = is_double_precision ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
                    else
                        spec_res_d = '0;
                    state_d = special_d ? S_PACK : S_MUL;
                end
            end
            S_MUL: begin
                acc_d  = sum[106:1];
                mplr_d = {1'b0, mplr_q[52:1]};
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == (dp_q ? 6'd52 : 6'd23)) state_d = S_NORM;
            end
            S_NORM: begin
                // Left-align the leading one to bit 105; covers both the [2,4) case and subnormals
                norm_d  = aligned << lz;
                e2_d    = (e_q <<< 1) + 13'sd1 - $signed({6'b0, lz});
                state_d = S_PACK;
            end
            S_PACK: begin
                state_d = S_DONE;
                valid_d = 1'b1;
                inv_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inx_d   = 1'b0;
                if (special_q) begin
                    result_d = spec_res_q;
                    inv_d    = spec_inv_q;
                end else if (e2r > emax) begin
                    result_d = dp_q ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
                    ovf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else if (e2r < emin) begin
                    result_d = '0;
                    unf_d    = 1'b1;
                    inx_d    = 1'b1;
                end else begin
                    result_d = dp_q ? {1'b0, biased[10:0], mant[51:0]}
                                    : {32'b0, 1'b0, biased[7:0], mant[22:0]};
                    inx_d    = inexact;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            result_q   <= '0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
            dp_q       <= 1'b0;
            mode_q     <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_inv_q <= 1'b0;
            m_q        <= '0;
            mplr_q     <= '0;
            acc_q      <= '0;
            norm_q     <= '0;
            cnt_q      <= '0;
            e_q        <= '0;
            e2_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            inv_q      <= inv_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inx_q      <= inx_d;
            dp_q       <= dp_d;
            mode_q     <= mode_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_inv_q <= spec_inv_d;
            m_q        <= m_d;
            mplr_q     <= mplr_d;
            acc_q      <= acc_d;
            norm_q     <= norm_d;
            cnt_q      <= cnt_d;
            e_q        <= e_d;
            e2_q       <= e2_d;
        end
    end

    assign ready          = ready_q;
    assign valid_out      = valid_q;
    assign result         = result_q;
    assign flag_invalid   = inv_q;
    assign flag_overflow  = ovf_q;
    assign flag_underflow = unf_q;
    assign flag_inexact   = inx_q;
    assign unused_bits    = ^{operand_a[63], operand_a[31], sum[0], mant[52], biased[12:11]};
endmodule

// File: tb/tb_fp_square_seq.sv
// Scoreboard bench for fp_square_seq: directed cases plus random operands against an arithmetic reference.
module tb_fp_square_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, is_double_precision;
    logic [63:0] operand_a, result;
    logic [2:0]  rounding_mode;
    logic        ready, valid_out, flag_invalid, flag_overflow, flag_underflow, flag_inexact;

    fp_square_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operand_a(operand_a),
        .is_double_precision(is_double_precision), .rounding_mode(rounding_mode),
        .ready(ready), .valid_out(valid_out), .result(result),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flags;
        int          edge_t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;
    bit   pend_off = 1'b0;
    bit   chain = 1'b0;
    int   prev_t = 0, prev_lat = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer product, remainder-based rounding, then range checks.
    function automatic void model(input logic [63:0] op, input logic dp, input logic [2:0] mode,
                                  output logic [63:0] res, output logic [3:0] fl, output logic spc);
        int fw, bias, k, sh, e, ee;
        longint unsigned ex, fr, m, keep;
        logic [127:0] p, rem, half, one;
        bit inx, up;
        fw   = dp ? 52 : 23;
        bias = dp ? 1023 : 127;
        ex   = dp ? 64'(op[62:52]) : 64'(op[30:23]);
        fr   = dp ? 64'(op[51:0]) : 64'(op[22:0]);
        res  = '0;
        fl   = '0;
        spc  = 1'b0;
        if (ex == (dp ? 64'd2047 : 64'd255)) begin
            spc = 1'b1;
            if (fr != 0) begin
                res   = dp ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
                fl[3] = ((fr >> (fw - 1)) & 64'd1) == 0;
            end else begin
                res = dp ? 64'h7FF0_0000_0000_0000 : 64'h7F80_0000;
            end
        end else if (ex == 0 && fr == 0) begin
            spc = 1'b1;
        end else begin
            m  = (ex != 0) ? ((64'd1 << fw) | fr) : fr;
            e  = (ex != 0) ? int'(ex) - bias : 1 - bias;
            p  = 128'(m) * 128'(m);
            k  = 0;
            for (int i = 0; i < 128; i++) if (p[i]) k = i;
            ee  = k + 2 * e - 2 * fw;
            one = 128'd1;
            inx = 1'b0;
            up  = 1'b0;
            if (k > fw) begin
                sh   = k - fw;
                keep = 64'(p >> sh);
                rem  = p - (128'(keep) << sh);
                half = one << (sh - 1);
                inx  = (rem != 0);
                if (mode == 3'b000)      up = (rem > half) || (rem == half && keep[0]);
                else if (mode == 3'b011) up = inx;
            end else begin
                keep = 64'(p << (fw - k));
            end
            keep = keep + 64'(up);
            if (keep == (64'd1 << (fw + 1))) begin
                keep = keep >> 1;
                ee++;
            end
            if (ee > bias) begin
                res = dp ? 64'h7FF0_0000_0000_0000 : 64'h7F80_0000;
                fl  = 4'b0101;
            end else if (ee < 1 - bias) begin
                res = '0;
                fl  = 4'b0011;
            end else begin
                res   = (64'(ee + bias) << fw) | (keep & ((64'd1 << fw) - 1));
                fl[0] = inx;
            end
        end
    endfunction

    function automatic logic [63:0] rand_op(input logic dp);
        int cls, bias, emaxf, ex;
        longint unsigned fr;
        logic sg;
        cls   = int'($urandom_range(0, 15));
        bias  = dp ? 1023 : 127;
        emaxf = dp ? 2047 : 255;
        sg    = 1'($urandom);
        fr    = {$urandom, $urandom};
        fr    = dp ? (fr & 64'h000F_FFFF_FFFF_FFFF) : (fr & 64'h007F_FFFF);
        case (cls)
            0: ex = emaxf;
            1: begin ex = emaxf; fr = 0; end
            2: begin ex = 0; fr = 0; end
            3: ex = 0;
            4: ex = int'($urandom_range(bias + bias / 2, emaxf - 1));
            5: ex = int'($urandom_range(1, bias / 2));
            6: begin ex = int'($urandom_range(bias - 4, bias + 4)); fr = fr & 64'hF; end
            7: ex = bias + bias / 2 + int'($urandom_range(0, 1));
            8: ex = bias - bias / 2 - int'($urandom_range(0, 1));
            default: ex = int'($urandom_range(bias - bias / 2, bias + bias / 2));
        endcase
        if (dp) return {sg, 11'(ex), fr[51:0]};
        return {$urandom, sg, 8'(ex), fr[22:0]};
    endfunction

    task automatic issue(input logic [63:0] op, input logic dp, input logic [2:0] mode,
                         input logic [63:0] eres, input logic [3:0] eflags, input int lat);
        int waited, t;
        waited = 0;
        @(negedge clk);
        while (!ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b, expected 1 within 300 cycles", ready);
            return;
        end
        operand_a = op;
        is_double_precision = dp;
        rounding_mode = mode;
        start = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        start = 1'b0;
        // Scramble inputs while busy; the operation must use its captured copies
        operand_a = {$urandom, $urandom};
        is_double_precision = ~dp;
        rounding_mode = 3'($urandom);
        sb.push_back('{eres, eflags, t + lat});
        check("ready_low_after_start", 64'(ready), 64'd0);
        if (chain) check("back_to_back_accept", 64'(t), 64'(prev_t + prev_lat + 1));
        chain = 1'b1;
        prev_t = t;
        prev_lat = lat;
    endtask

    task automatic issue_rand();
        logic dp, spc;
        logic [2:0] mode;
        logic [63:0] op, res;
        logic [3:0] fl;
        dp = 1'($urandom);
        case ($urandom_range(0, 3))
            0: mode = 3'b000;
            1: mode = 3'b011;
            default: mode = 3'($urandom);
        endcase
        op = rand_op(dp);
        model(op, dp, mode, res, fl, spc);
        issue(op, dp, mode, res, fl, spc ? 2 : (dp ? 56 : 27));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: outstanding=%0d, expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_off = 1'b0;
            end else begin
                if (pend_off) begin
                    check("valid_single_pulse", 64'(valid_out), 64'd0);
                    pend_off = 1'b0;
                end
                if (valid_out) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: valid_out=1 with no outstanding request (cycle %0d)", cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        check("result", result, mon_e.res);
                        check("flags", 64'({flag_invalid, flag_overflow, flag_underflow, flag_inexact}), 64'(mon_e.flags));
                        check("latency_edge", 64'(cyc + 1), 64'(mon_e.edge_t));
                    end
                    pend_off = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        start = 1'b1;
        operand_a = 64'h4008_0000_0000_0000;
        is_double_precision = 1'b1;
        rounding_mode = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_valid", 64'(valid_out), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_flags", 64'({flag_invalid, flag_overflow, flag_underflow, flag_inexact}), 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        issue(64'h4008_0000_0000_0000, 1'b1, 3'b000, 64'h4022_0000_0000_0000, 4'b0000, 56);
        issue(64'hDEAD_BEEF_3F80_0001, 1'b0, 3'b000, 64'h0000_0000_3F80_0002, 4'b0001, 27);
        issue(64'h0000_0000_3F80_0001, 1'b0, 3'b011, 64'h0000_0000_3F80_0003, 4'b0001, 27);
        issue(64'h0000_0000_3F80_0001, 1'b0, 3'b001, 64'h0000_0000_3F80_0002, 4'b0001, 27);
        issue(64'h0000_0000_C000_0000, 1'b0, 3'b000, 64'h0000_0000_4080_0000, 4'b0000, 27);
        issue(64'h6974_E718_D7D7_625A, 1'b1, 3'b000, 64'h7FF0_0000_0000_0000, 4'b0101, 56);
        issue(64'h0000_0000_0000_0001, 1'b0, 3'b000, 64'h0000_0000_0000_0000, 4'b0011, 27);
        issue(64'h0000_0000_7F80_0001, 1'b0, 3'b000, 64'h0000_0000_7FC0_0000, 4'b1000, 2);
        issue(64'hFFF0_0000_0000_0000, 1'b1, 3'b000, 64'h7FF0_0000_0000_0000, 4'b0000, 2);

        for (int n = 0; n < 40; n++) issue_rand();
        drain();

        // Abort: ignored start while busy, then reset mid-multiply
        chain = 1'b0;
        operand_a = 64'h4008_0000_0000_0000;
        is_double_precision = 1'b1;
        rounding_mode = 3'b000;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        check("abort_ready_busy", 64'(ready), 64'd0);
        while (cyc < t0 + 9) @(negedge clk);
        operand_a = 64'h3FF0_0000_0000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored_start_ready", 64'(ready), 64'd0);
        while (cyc < t0 + 19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_valid", 64'(valid_out), 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_flags", 64'({flag_invalid, flag_overflow, flag_underflow, flag_inexact}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        issue(64'h3FF8_0000_0000_0000, 1'b1, 3'b000, 64'h4002_0000_0000_0000, 4'b0000, 56);
        check("restart_accept_edge", 64'(prev_t), 64'(t0 + 22));

        for (int n = 0; n < 8; n++) issue_rand();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
